// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//
// Sequential load/store control unit feeding the MEM stage. Takes one memory
// operation at a time from execute (valid/ready), checks op legality and
// alignment, drives MEM for a bounded number of cycles and hands the result
// to writeback (valid/ready).
//
// Loads are issued as aligned doubleword reads held for LAT cycles; the
// addressed lane is then shifted down and zero/sign-extended. Stores are
// passed through for a single cycle with the original address and op code.
// Misaligned or illegal ops never touch MEM and complete immediately with
// out_fault=1 and the faulting address on out_data.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid/in_ready       request handshake
//   in_addr/in_wdata/in_op  request byte address, store data, op code
//   in_rd                   destination register tag
//   mem_en/mem_addr         MEM enable and address
//   mem_wdata/mem_ctrl      MEM write data and control (op code for stores)
//   mem_rdata               MEM read data
//   out_valid/out_ready     result handshake
//   out_data                load result or faulting address
//   out_rd                  tag of the completed op
//   out_wen                 1 for a completed legal load
//   out_fault               1 for a misaligned or illegal op
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int unsigned LAT = 1   // load access cycles, 1..15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_addr,
    input  logic [63:0] in_wdata,
    input  logic [3:0]  in_op,
    input  logic [4:0]  in_rd,
    output logic        mem_en,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [3:0]  mem_ctrl,
    input  logic [63:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_fault
);

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    // Op codes
    localparam logic [3:0] OP_L8  = 4'b0000;
    localparam logic [3:0] OP_L2  = 4'b0001;
    localparam logic [3:0] OP_L1  = 4'b0010;
    localparam logic [3:0] OP_L4S = 4'b0011;
    localparam logic [3:0] OP_L2S = 4'b0100;
    localparam logic [3:0] OP_L4  = 4'b0101;
    localparam logic [3:0] OP_S8  = 4'b1000;
    localparam logic [3:0] OP_S4  = 4'b1001;
    localparam logic [3:0] OP_S2  = 4'b1010;
    localparam logic [3:0] OP_S1  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic        wen_q, wen_d;
    logic        fault_q, fault_d;

    // -----------------------------------------------------------------------
    // Request decode: legality and alignment of the incoming op
    // -----------------------------------------------------------------------
    logic req_legal;
    logic req_aligned;

    always_comb begin
        req_legal   = 1'b1;
        req_aligned = 1'b1;
        unique case (in_op)
            OP_L8, OP_S8:          req_aligned = (in_addr[2:0] == 3'b000);
            OP_L4S, OP_L4, OP_S4:  req_aligned = (in_addr[1:0] == 2'b00);
            OP_L2, OP_L2S, OP_S2:  req_aligned = (in_addr[0] == 1'b0);
            OP_L1, OP_S1:          req_aligned = 1'b1;
            default:               req_legal   = 1'b0;
        endcase
    end

    // Latched op is a load when the top bit is clear (illegal ops never
    // reach ACCESS, so only legal codes are seen here).
    logic is_load;
    assign is_load = ~op_q[3];

    // -----------------------------------------------------------------------
    // Load lane extraction: shift the addressed byte down to bit 0, then
    // extend according to the access width.
    // -----------------------------------------------------------------------
    logic [63:0] lane;
    logic [63:0] load_val;

    assign lane = mem_rdata >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_val = lane;
        unique case (op_q)
            OP_L8:   load_val = lane;
            OP_L2:   load_val = {48'd0, lane[15:0]};
            OP_L1:   load_val = {56'd0, lane[7:0]};
            OP_L4S:  load_val = {{32{lane[31]}}, lane[31:0]};
            OP_L2S:  load_val = {{48{lane[15]}}, lane[15:0]};
            OP_L4:   load_val = {32'd0, lane[31:0]};
            default: load_val = lane;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        wen_d   = wen_q;
        fault_d = fault_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    op_d    = in_op;
                    rd_d    = in_rd;
                    if (req_legal && req_aligned) begin
                        state_d = ST_ACCESS;
                        // Stores take exactly one ACCESS cycle whatever LAT is.
                        cnt_d   = in_op[3] ? 4'd1 : LAT_CNT;
                    end else begin
                        state_d = ST_DONE;
                        res_d   = in_addr;
                        wen_d   = 1'b0;
                        fault_d = 1'b1;
                    end
                end
            end

            ST_ACCESS: begin
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                    fault_d = 1'b0;
                    if (is_load) begin
                        res_d = load_val;
                        wen_d = 1'b1;
                    end else begin
                        res_d = 64'd0;
                        wen_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    // Clear the result so nothing stale is visible in IDLE.
                    res_d   = 64'd0;
                    wen_d   = 1'b0;
                    fault_d = 1'b0;
                    rd_d    = 5'd0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            op_q    <= 4'd0;
            rd_q    <= 5'd0;
            cnt_q   <= 4'd0;
            res_q   <= 64'd0;
            wen_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            wen_q   <= wen_d;
            fault_q <= fault_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from registered state only, so in_* changes after
    // acceptance cannot reach MEM. in_ready is gated by rst_n so it is low
    // for the whole reset interval.
    // -----------------------------------------------------------------------
    logic in_access;
    assign in_access = (state_q == ST_ACCESS);

    assign in_ready  = rst_n && (state_q == ST_IDLE);
    assign mem_en    = in_access;
    assign mem_addr  = !in_access ? 64'd0 :
                       is_load    ? {addr_q[63:3], 3'b000} : addr_q;
    assign mem_ctrl  = (in_access && !is_load) ? op_q    : 4'd0;
    assign mem_wdata = (in_access && !is_load) ? wdata_q : 64'd0;

    assign out_valid = (state_q == ST_DONE);
    assign out_data  = res_q;
    assign out_rd    = rd_q;
    assign out_wen   = wen_q;
    assign out_fault = fault_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
//
// Two instances of lsu_ctrl (LAT=1 and LAT=3) share the request, MEM read
// and reset signals; each has its own in_valid and out_ready so only one is
// active at a time. Expected results come from a width/offset model of the
// op codes written with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [3:0]  in_op;
    logic [4:0]  in_rd;
    logic [63:0] mem_rdata;

    logic        in_valid_a  [2];
    logic        out_ready_a [2];
    logic        in_ready_a  [2];
    logic        mem_en_a    [2];
    logic [63:0] mem_addr_a  [2];
    logic [63:0] mem_wdata_a [2];
    logic [3:0]  mem_ctrl_a  [2];
    logic        out_valid_a [2];
    logic [63:0] out_data_a  [2];
    logic [4:0]  out_rd_a    [2];
    logic        out_wen_a   [2];
    logic        out_fault_a [2];

    int total;
    int bad;

    lsu_ctrl #(.LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_op(in_op), .in_rd(in_rd),
        .mem_en(mem_en_a[0]), .mem_addr(mem_addr_a[0]),
        .mem_wdata(mem_wdata_a[0]), .mem_ctrl(mem_ctrl_a[0]),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
        .out_data(out_data_a[0]), .out_rd(out_rd_a[0]),
        .out_wen(out_wen_a[0]), .out_fault(out_fault_a[0])
    );

    lsu_ctrl #(.LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_op(in_op), .in_rd(in_rd),
        .mem_en(mem_en_a[1]), .mem_addr(mem_addr_a[1]),
        .mem_wdata(mem_wdata_a[1]), .mem_ctrl(mem_ctrl_a[1]),
        .mem_rdata(mem_rdata),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
        .out_data(out_data_a[1]), .out_rd(out_rd_a[1]),
        .out_wen(out_wen_a[1]), .out_fault(out_fault_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes (0 = illegal op), fault rule,
    // and the value a legal load must return.
    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            4'h0, 4'h8:       return 8;
            4'h3, 4'h5, 4'h9: return 4;
            4'h1, 4'h4, 4'hA: return 2;
            4'h2, 4'hB:       return 1;
            default:          return 0;
        endcase
    endfunction

    function automatic logic [63:0] load_model(input logic [3:0] op,
                                               input logic [63:0] addr,
                                               input logic [63:0] rdata);
        int          n;
        logic [63:0] v;
        logic [63:0] mask;
        n = op_bytes(op);
        v = rdata >> (8 * int'(addr[2:0]));
        if (n < 8) begin
            mask = (64'd1 << (8 * n)) - 64'd1;
            v    = v & mask;
            if ((op == 4'h3 || op == 4'h4) && v[8*n-1])
                v = v | ~mask;
        end
        return v;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // One complete transaction on instance d, with `hold` cycles of
    // writeback backpressure after out_valid rises.
    task automatic run_op(input int d, input logic [3:0] op, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata,
                          input logic [4:0] rd, input int hold);
        int          n;
        int          lat;
        int          exp_vk;
        int          exp_en;
        int          vk;
        int          en_cnt;
        int          w;
        logic        fault;
        logic        is_load;
        logic [63:0] exp_data;
        logic [63:0] exp_maddr;
        logic [63:0] exp_mwdata;
        logic [3:0]  exp_mctrl;

        n       = op_bytes(op);
        lat     = lat_of(d);
        fault   = (n == 0) || ((addr % 64'(n)) != 64'd0);
        is_load = (op < 4'h8);
        if (fault) begin
            exp_data = addr; exp_vk = 1; exp_en = 0;
        end else if (is_load) begin
            exp_data = load_model(op, addr, rdata); exp_vk = lat + 1; exp_en = lat;
        end else begin
            exp_data = 64'd0; exp_vk = 2; exp_en = 1;
        end
        exp_maddr  = is_load ? (addr & ~64'd7) : addr;
        exp_mctrl  = is_load ? 4'd0 : op;
        exp_mwdata = is_load ? 64'd0 : wdata;

        w = 0;
        while (!in_ready_a[d] && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk("in_ready_before", 64'(in_ready_a[d]), 64'd1);

        in_op = op; in_addr = addr; in_wdata = wdata; in_rd = rd;
        in_valid_a[d] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[d] = 1'b0;
        // Scramble the request inputs; the unit must ignore them now.
        in_op = 4'($urandom); in_addr = {$urandom, $urandom};
        in_wdata = {$urandom, $urandom}; in_rd = 5'($urandom);

        vk = 0; en_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            // Correct read data only during the final ACCESS cycle.
            mem_rdata = (c == lat) ? rdata : {$urandom, $urandom};
            if (out_valid_a[d]) begin
                vk = c;
                break;
            end
            if (mem_en_a[d]) begin
                en_cnt++;
                chk("mem_addr", mem_addr_a[d], exp_maddr);
                chk("mem_ctrl", 64'(mem_ctrl_a[d]), 64'(exp_mctrl));
                chk("mem_wdata", mem_wdata_a[d], exp_mwdata);
            end else begin
                chk("mem_idle_zero", {mem_addr_a[d] | mem_wdata_a[d]}, 64'd0);
            end
            @(posedge clk); #1;
        end
        chk("valid_latency", 64'(vk), 64'(exp_vk));
        chk("mem_en_cycles", 64'(en_cnt), 64'(exp_en));
        chk("out_data", out_data_a[d], exp_data);
        chk("out_wen", 64'(out_wen_a[d]), 64'(is_load && !fault));
        chk("out_fault", 64'(out_fault_a[d]), 64'(fault));
        chk("out_rd", 64'(out_rd_a[d]), 64'(rd));
        chk("mem_en_done", 64'(mem_en_a[d]), 64'd0);
        chk("in_ready_done", 64'(in_ready_a[d]), 64'd0);

        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            mem_rdata = {$urandom, $urandom};
            chk("hold_valid", 64'(out_valid_a[d]), 64'd1);
            chk("hold_data", out_data_a[d], exp_data);
            chk("hold_flags", {out_wen_a[d], out_fault_a[d], out_rd_a[d]},
                64'({(is_load && !fault), fault, rd}));
            chk("hold_in_ready", 64'(in_ready_a[d]), 64'd0);
        end

        out_ready_a[d] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[d] = 1'b0;
        chk("release_valid", 64'(out_valid_a[d]), 64'd0);
        chk("release_in_ready", 64'(in_ready_a[d]), 64'd1);
        $display("txn dut=%0d op=%h addr=%h data=%h fault=%0d lat=%0d", d, op, addr,
                 out_data_a[d], fault, vk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        in_addr = '0; in_wdata = '0; in_op = '0; in_rd = '0; mem_rdata = '0;
        for (int d = 0; d < 2; d++) begin
            in_valid_a[d]  = 1'b0;
            out_ready_a[d] = 1'b0;
        end

        // Reset state
        #3;
        for (int d = 0; d < 2; d++) begin
            chk("rst_in_ready", 64'(in_ready_a[d]), 64'd0);
            chk("rst_mem", {mem_addr_a[d] | mem_wdata_a[d]}, 64'd0);
            chk("rst_mem_ctl", 64'({mem_en_a[d], mem_ctrl_a[d]}), 64'd0);
            chk("rst_out", out_data_a[d], 64'd0);
            chk("rst_out_ctl", 64'({out_valid_a[d], out_wen_a[d], out_fault_a[d], out_rd_a[d]}),
                64'd0);
        end
        #19 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready0", 64'(in_ready_a[0]), 64'd1);
        chk("post_rst_ready1", 64'(in_ready_a[1]), 64'd1);

        // Directed cases
        run_op(0, 4'h3, 64'h8000_0004, 64'd0, 64'h8000_0001_1234_5678, 5'd7, 0);
        run_op(0, 4'h2, 64'h8000_0003, 64'd0, 64'h0000_0000_AB00_0000, 5'd3, 0);
        run_op(1, 4'h2, 64'h8000_0003, 64'd0, 64'h0000_0000_AB00_0000, 5'd4, 0);
        run_op(0, 4'hA, 64'h8000_0006, 64'h1234, 64'd0, 5'd9, 0);
        run_op(1, 4'hA, 64'h8000_0006, 64'h1234, 64'd0, 5'd9, 0);
        run_op(0, 4'h0, 64'h8000_0004, 64'd0, 64'd0, 5'd1, 0);
        run_op(1, 4'h7, 64'h8000_0004, 64'd0, 64'd0, 5'd2, 0);
        run_op(1, 4'h0, 64'h8000_0008, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 5'd5, 0);
        run_op(1, 4'h4, 64'h8000_0006, 64'd0, 64'h9ABC_0000_0000_0000, 5'd6, 0);
        // Backpressure then a back-to-back load
        run_op(1, 4'h5, 64'h8000_0004, 64'd0, 64'hF123_4567_0000_0000, 5'd10, 5);
        run_op(1, 4'h1, 64'h8000_0002, 64'd0, 64'h0000_0000_8765_0000, 5'd11, 0);

        // Reset during the second ACCESS cycle of a LAT=3 load
        in_op = 4'h0; in_addr = 64'h8000_0010; in_rd = 5'd12; in_valid_a[1] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[1] = 1'b0;
        chk("mid_acc1_en", 64'(mem_en_a[1]), 64'd1);
        @(posedge clk); #1;
        chk("mid_acc2_en", 64'(mem_en_a[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_en", 64'(mem_en_a[1]), 64'd0);
        chk("rst_drop_addr", mem_addr_a[1], 64'd0);
        chk("rst_drop_valid", 64'(out_valid_a[1]), 64'd0);
        chk("rst_drop_ready", 64'(in_ready_a[1]), 64'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_valid", 64'(out_valid_a[1]), 64'd0);
        chk("after_rst_ready", 64'(in_ready_a[1]), 64'd1);
        chk("after_rst_en", 64'(mem_en_a[1]), 64'd0);
        run_op(1, 4'h3, 64'h8000_0014, 64'd0, 64'h7FFF_FFFF_0000_0000, 5'd13, 0);

        // Randomized ops across both latencies
        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 1)), 4'($urandom),
                   {32'h8000_0000, 24'($urandom), 8'($urandom)},
                   {$urandom, $urandom}, {$urandom, $urandom},
                   5'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Sequential load/store control unit sitting directly upstream of the `MEM` stage. It accepts one memory operation at a time from the execute stage over a valid/ready handshake and checks alignment. It drives `MEM` for a bounded number of cycles, with loads issued as aligned doubleword reads, then extracts and extends the addressed lane. The result is held for the writeback stage under a second valid/ready handshake.

## Interface
- `LAT`, 1: cycles `mem_en` is held for a load before `mem_rdata` is captured; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  unit can accept a request.
- `in_addr`  in  64  byte address.
- `in_wdata`  in  64  store data, low bytes significant.
- `in_op`  in  4  loads: 0000 L8, 0001 L2, 0010 L1, 0011 L4 sign-extended, 0100 L2 sign-extended, 0101 L4; stores: 1000 S8, 1001 S4, 1010 S2, 1011 S1.
- `in_rd`  in  5  destination register tag.
- `mem_en`  out  1  to `MEM_Enable`.
- `mem_addr`  out  64  to `MEM_Address`.
- `mem_wdata`  out  64  to `Data_Write`.
- `mem_ctrl`  out  4  to `Ctrl`.
- `mem_rdata`  in  64  from `MEM_Data_out`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  writeback can accept.
- `out_data`  out  64  load result, or faulting address.
- `out_rd`  out  5  tag of the completed operation.
- `out_wen`  out  1  1 for a completed legal load.
- `out_fault`  out  1  1 for a misaligned or illegal op.

## Operation
- States:
  - IDLE: `in_ready`=1 while `rst_n`=1.
  - ACCESS: drives `mem_*`.
  - DONE: `out_valid`=1.
- IDLE transitions, when `in_valid && in_ready`, latch addr, wdata, op, and rd, then:
  - Legal and aligned → ACCESS.
  - Otherwise → DONE with `out_fault`=1, `out_data`=`in_addr`, `out_wen`=0. `mem_en` is never asserted.
- Alignment rules:
  - L8/S8 need `addr[2:0]`=0.
  - L4/S4 need `addr[1:0]`=0.
  - L2/S2 need `addr[0]`=0.
  - Byte ops are always aligned.
- Illegal op codes: 0110, 0111, 11xx.
- Load in ACCESS:
  - `mem_addr` = `{addr[63:3],3'b000}`, `mem_ctrl`=0000, `mem_en`=1, `mem_wdata`=0, for exactly `LAT` cycles (4-bit down-counter).
  - On the last cycle, capture `lane = mem_rdata >> (8*addr[2:0])`.
  - Extend per op: zero-extend for 0001/0010/0101, sign-extend for 0011/0100, full 64 bits for 0000.
  - Then → DONE with `out_wen`=1.
- Store in ACCESS:
  - `mem_addr`=`addr` unmodified, `mem_ctrl`=`op`, `mem_wdata`=`wdata`, `mem_en`=1 for exactly one cycle regardless of `LAT`.
  - Then → DONE with `out_wen`=0, `out_data`=0.
- DONE: hold all `out_*` stable until `out_ready`=1, then → IDLE.
- `mem_en`, `mem_addr`, `mem_ctrl`, and `mem_wdata` are 0 outside ACCESS.

## Timing
- Reset (async, immediate):
  - State IDLE, counter 0.
  - All `out_*` and `mem_*` = 0.
  - `in_ready`=0 while `rst_n`=0, and 1 from the first cycle after deassertion.
- Accept at edge T:
  - Load: ACCESS in cycles T+1..T+LAT, `out_valid` from T+LAT+1.
  - Store: ACCESS in cycle T+1, `out_valid` from T+2.
  - Fault: `out_valid` from T+1.
- DONE with `out_ready`=1 in the same cycle: IDLE next cycle. `in_ready` is never high in DONE.
- Throughput is one op per LAT+2 cycles for loads with no backpressure.
- Reset asserted mid-ACCESS or mid-DONE:
  - `mem_en` and `out_valid` drop immediately.
  - No capture, no completion, operation discarded.
- `in_*` are ignored outside IDLE; their changes during ACCESS do not affect `mem_*`.

## Test plan
- **Sign-extended word load.** LAT=1, op 0011, addr 0x8000_0004, `mem_rdata`=0x8000_0001_1234_5678.
  - Expected: `mem_addr`=0x8000_0000, `mem_ctrl`=0000 for 1 cycle.
  - Expected: `out_data`=0xFFFF_FFFF_8000_0001, `out_wen`=1, `out_valid` at T+2.
- **Byte load at offset 3.** op 0010, addr 0x8000_0003, `mem_rdata`=0x0000_0000_AB00_0000.
  - Expected: `out_data`=0x0000_0000_0000_00AB.
- **Halfword store.** op 1010, addr 0x8000_0006, wdata 0x1234.
  - Expected: exactly one `mem_en` cycle with `mem_addr`=0x8000_0006, `mem_ctrl`=1010, `mem_wdata`=0x1234.
  - Expected: `out_valid` at T+2, `out_wen`=0.
- **Misaligned doubleword load.** op 0000, addr 0x8000_0004.
  - Expected: `mem_en` stays 0, `out_fault`=1, `out_data`=0x8000_0004, `out_valid` at T+1.
  - Same check for op 0111 (illegal op).
- **Backpressure.** `out_ready`=0 for 5 cycles after `out_valid`.
  - Expected: `out_*` stable, `in_ready`=0 throughout.
  - Raise `out_ready`: `in_ready`=1 next cycle.
  - Back-to-back second load completes correctly.
- **Reset mid-access.** LAT=3, assert `rst_n`=0 during the second ACCESS cycle.
  - Expected: `mem_en`=0 immediately.
  - Expected after release: `out_valid`=0, `in_ready`=1, a new request completes normally.
